// File: rtl/sr_pkg.sv
// rtl/sr_pkg.sv - shared command encodings, FSM state type and SR helper
package sr_pkg;

    localparam logic [1:0] SR_NOP = 2'b00;
    localparam logic [1:0] SR_CLR = 2'b01;
    localparam logic [1:0] SR_SET = 2'b10;
    localparam logic [1:0] SR_BAD = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } fsm_state_e;

    // Next value of one flag under an {s,r} command; NOP and BAD hold it.
    function automatic logic sr_apply(input logic cur, input logic [1:0] cmd);
        logic nxt;
        nxt = cur;
        case (cmd)
            SR_SET:  nxt = 1'b1;
            SR_CLR:  nxt = 1'b0;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, one-hot grant, pointer advances past the winner
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            adv,
    output logic [NREQ-1:0] gnt
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            int k;
            k = int'(ptr_q) + i;
            if (k >= NREQ) k = k - NREQ;
            if (!found && req[k]) begin
                gnt[k] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    // Pointer only moves when the caller actually consumes the grant.
    always_comb begin
        ptr_d = ptr_q;
        if (adv) begin
            for (int k = 0; k < NREQ; k++) begin
                if (gnt[k]) ptr_d = (k == NREQ - 1) ? '0 : PW'(k + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/sr_flag_arbiter.sv
// rtl/sr_flag_arbiter.sv - round-robin arbitrated writer of a shared set/reset flag bank
module sr_flag_arbiter
    import sr_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int NFLAG = 8,
    localparam int IDXW  = $clog2(NFLAG)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    req_sr,
    input  logic [IDXW*NREQ-1:0] req_idx,
    input  logic                 clr_all,
    output logic [NREQ-1:0]      gnt,
    output logic                 err,
    output logic [NFLAG-1:0]     flags,
    output logic [NFLAG-1:0]     flags_n
);

    logic [NREQ-1:0]  arb_gnt;
    logic             accept;
    logic [1:0]       sel_sr;
    logic [IDXW-1:0]  sel_idx;
    logic             idx_ok;

    fsm_state_e       state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             err_q, err_d;
    logic [NFLAG-1:0] flags_q, flags_d;

    assign accept = (|req) && !clr_all;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .adv   (accept),
        .gnt   (arb_gnt)
    );

    always_comb begin
        sel_sr  = SR_NOP;
        sel_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (arb_gnt[k]) begin
                sel_sr  = req_sr[2*k +: 2];
                sel_idx = req_idx[IDXW*k +: IDXW];
            end
        end
        idx_ok = int'(sel_idx) < NFLAG;
    end

    // clr_all wins over any command; otherwise at most the one addressed flag moves.
    always_comb begin
        flags_d = flags_q;
        if (clr_all) begin
            flags_d = '0;
        end else if (accept && idx_ok) begin
            for (int f = 0; f < NFLAG; f++) begin
                if (f == int'(sel_idx)) flags_d[f] = sr_apply(flags_q[f], sel_sr);
            end
        end
    end

    always_comb begin
        gnt_d   = accept ? arb_gnt : '0;
        err_d   = accept && ((sel_sr == SR_BAD) || !idx_ok);
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)  state_d = GRANT;
            GRANT:   if (!accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            err_q   <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            err_q   <= err_d;
            flags_q <= flags_d;
        end
    end

    assign gnt     = gnt_q;
    assign err     = err_q;
    assign flags   = flags_q;
    assign flags_n = ~flags_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb/tb_sr_flag_arbiter.sv - directed self-checking bench for sr_flag_arbiter
module tb_sr_flag_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] req_sr;
    logic [11:0] req_idx;
    logic       clr_all;
    logic [3:0] gnt;
    logic       err;
    logic [7:0] flags;
    logic [7:0] flags_n;

    logic [3:0]  r9_req;
    logic [7:0]  r9_sr;
    logic [15:0] r9_idx;
    logic [3:0]  r9_gnt;
    logic        r9_err;
    logic [8:0]  r9_flags;
    logic [8:0]  r9_flags_n;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sr_flag_arbiter #(.NREQ(4), .NFLAG(8)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .req_sr  (req_sr),
        .req_idx (req_idx),
        .clr_all (clr_all),
        .gnt     (gnt),
        .err     (err),
        .flags   (flags),
        .flags_n (flags_n)
    );

    sr_flag_arbiter #(.NREQ(4), .NFLAG(9)) u_dut9 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (r9_req),
        .req_sr  (r9_sr),
        .req_idx (r9_idx),
        .clr_all (1'b0),
        .gnt     (r9_gnt),
        .err     (r9_err),
        .flags   (r9_flags),
        .flags_n (r9_flags_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int k, input logic [1:0] sr, input logic [2:0] idx);
        req[k]             = 1'b1;
        req_sr[2*k +: 2]   = sr;
        req_idx[3*k +: 3]  = idx;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = '0;
        req_sr  = '0;
        req_idx = '0;
        clr_all = 1'b0;
        r9_req  = '0;
        r9_sr   = '0;
        r9_idx  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_flags",   32'(flags),   32'h00);
        check("rst_flags_n", 32'(flags_n), 32'hFF);
        check("rst_gnt",     32'(gnt),     32'h0);
        check("rst_err",     32'(err),     32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // single set of flag 3 by requester 0
        put(0, 2'b10, 3'd3);
        step();
        check("t1_gnt",     32'(gnt),     32'h1);
        check("t1_flags",   32'(flags),   32'h08);
        check("t1_flags_n", 32'(flags_n), 32'hF7);
        check("t1_err",     32'(err),     32'h0);
        req[0] = 1'b0;
        step();
        check("t1_gnt_drop", 32'(gnt), 32'h0);

        // all four compete from pointer 0
        pulse_reset();
        for (int k = 0; k < 4; k++) put(k, 2'b10, 3'(k));
        for (int k = 0; k < 4; k++) begin
            logic [3:0] eg;
            logic [7:0] ef;
            eg = 4'b0001 << k;
            ef = 8'((16'h1 << (k + 1)) - 1);
            step();
            check($sformatf("t2_gnt%0d", k),   32'(gnt),   32'(eg));
            check($sformatf("t2_flags%0d", k), 32'(flags), 32'(ef));
            req[k] = 1'b0;
        end
        step();
        check("t2_idle_gnt", 32'(gnt), 32'h0);

        // bad command and NOP on flag 5
        pulse_reset();
        put(2, 2'b10, 3'd5);
        step();
        check("t3_pre_flags", 32'(flags), 32'h20);
        put(2, 2'b11, 3'd5);
        step();
        check("t3_gnt",   32'(gnt),   32'h4);
        check("t3_err",   32'(err),   32'h1);
        check("t3_flags", 32'(flags), 32'h20);
        put(2, 2'b00, 3'd5);
        step();
        check("t3_nop_gnt",   32'(gnt),   32'h4);
        check("t3_nop_err",   32'(err),   32'h0);
        check("t3_nop_flags", 32'(flags), 32'h20);
        req[2] = 1'b0;
        step();
        check("t3_err_clear", 32'(err),   32'h0);
        check("t3_flags_end", 32'(flags), 32'h20);

        // fill the bank, then clr_all against a pending request
        for (int f = 0; f < 8; f++) begin
            put(0, 2'b10, 3'(f));
            step();
        end
        req[0] = 1'b0;
        check("t4_full", 32'(flags), 32'hFF);
        put(1, 2'b10, 3'd7);
        clr_all = 1'b1;
        step();
        check("t4_clr_flags", 32'(flags), 32'h00);
        check("t4_clr_gnt",   32'(gnt),   32'h0);
        check("t4_clr_err",   32'(err),   32'h0);
        clr_all = 1'b0;
        step();
        check("t4_after_gnt",   32'(gnt),   32'h2);
        check("t4_after_flags", 32'(flags), 32'h80);
        req[1] = 1'b0;

        // asynchronous reset with pointer at 2, requesters 3 and 0 waiting
        put(3, 2'b10, 3'd3);
        put(0, 2'b10, 3'd0);
        rst_n = 1'b0;
        #1;
        check("t5_async_gnt",   32'(gnt),   32'h0);
        check("t5_async_flags", 32'(flags), 32'h00);
        check("t5_async_err",   32'(err),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("t5_first_gnt", 32'(gnt),   32'h1);
        check("t5_flags0",    32'(flags), 32'h01);
        req[0] = 1'b0;
        step();
        check("t5_second_gnt", 32'(gnt),   32'h8);
        check("t5_flags1",     32'(flags), 32'h09);
        req[3] = 1'b0;

        // out-of-range index on a 9-flag bank
        r9_req[1]    = 1'b1;
        r9_sr[3:2]   = 2'b10;
        r9_idx[7:4]  = 4'd8;
        step();
        check("t6_top_gnt",   32'(r9_gnt),   32'h2);
        check("t6_top_err",   32'(r9_err),   32'h0);
        check("t6_top_flags", 32'(r9_flags), 32'h100);
        r9_idx[7:4] = 4'd9;
        step();
        check("t6_oor_gnt",     32'(r9_gnt),     32'h2);
        check("t6_oor_err",     32'(r9_err),     32'h1);
        check("t6_oor_flags",   32'(r9_flags),   32'h100);
        check("t6_oor_flags_n", 32'(r9_flags_n), 32'h0FF);
        r9_req = '0;
        step();
        check("t6_idle_err", 32'(r9_err), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
